// File: rtl/imem_loader_pkg.sv
// Shared definitions for boot-time instruction memory loaders.
// Frame state encoding, sync marker default and datapath widths.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CNT_HI,
      S_CNT_LO,
      S_DATA,
      S_CHECK,
      S_DONE,
      S_ERROR
   } frame_state_t;

   localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
   localparam int WORD_W = 32;
   localparam int CNT_W  = 16;

endpackage

// File: rtl/imem_word_assembler.sv
// Packs big-endian bytes into 32-bit words and issues one-cycle
// instruction-memory writes at consecutive word addresses.
module imem_word_assembler
   import imem_loader_pkg::*;
#(
   parameter logic [WORD_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              shift,
   input  logic [7:0]        data_byte,
   output logic              word_done,
   output logic              wr_en,
   output logic [WORD_W-1:0] wr_addr,
   output logic [WORD_W-1:0] wr_data,
   output logic [CNT_W-1:0]  word_index
);

   logic [1:0]  byte_idx;
   logic [23:0] partial;
   logic [WORD_W-1:0] offset;

   assign word_done = shift && (byte_idx == 2'd3);
   assign offset = {{(WORD_W-CNT_W-2){1'b0}}, word_index, 2'b00};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_idx   <= '0;
         partial    <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= BASE_ADDR;
         wr_data    <= '0;
         word_index <= '0;
      end else begin
         wr_en <= word_done;
         if (clear) begin
            byte_idx   <= '0;
            word_index <= '0;
         end else if (shift) begin
            partial  <= {partial[15:0], data_byte};
            byte_idx <= byte_idx + 2'd1;
            // Address uses the index before it advances past this word.
            if (byte_idx == 2'd3) begin
               wr_data    <= {partial, data_byte};
               wr_addr    <= BASE_ADDR + offset;
               word_index <= word_index + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Frame receiver that loads instruction memory at boot and holds
// the CPU until a frame with a valid checksum has been stored.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int               DEPTH_WORDS = 64,
   parameter logic [WORD_W-1:0] BASE_ADDR  = 32'h0000_0000,
   parameter logic [7:0]       SYNC_BYTE   = SYNC_DEFAULT
) (
   input  logic              i_Clk,
   input  logic              i_Rst,
   input  logic [7:0]        i_Byte,
   input  logic              i_ByteValid,
   output logic              o_ByteReady,
   output logic              o_WrEn,
   output logic [WORD_W-1:0] o_WrAddr,
   output logic [WORD_W-1:0] o_WrData,
   output logic              o_CpuHold,
   output logic              o_Done,
   output logic              o_Error,
   output logic [CNT_W-1:0]  o_WordsLoaded
);

   localparam logic [CNT_W-1:0] DEPTH_N = CNT_W'(DEPTH_WORDS);

   frame_state_t state;
   logic [7:0]       cnt_hi;
   logic [CNT_W-1:0] n_words;
   logic [7:0]       acc;
   logic             accept;
   logic             is_sync;
   logic             start;
   logic             shift;
   logic             word_done;
   logic [CNT_W-1:0] count;

   assign accept  = i_ByteValid && o_ByteReady;
   assign is_sync = (i_Byte == SYNC_BYTE);
   assign start   = accept && is_sync &&
                    (state == S_IDLE || state == S_DONE ||
                     state == S_ERROR);
   assign shift   = accept && (state == S_DATA);
   assign count   = {cnt_hi, i_Byte};

   imem_word_assembler #(
      .BASE_ADDR (BASE_ADDR)
   ) u_asm (
      .clk        (i_Clk),
      .rst        (i_Rst),
      .clear      (start),
      .shift      (shift),
      .data_byte  (i_Byte),
      .word_done  (word_done),
      .wr_en      (o_WrEn),
      .wr_addr    (o_WrAddr),
      .wr_data    (o_WrData),
      .word_index (o_WordsLoaded)
   );

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         state       <= S_IDLE;
         cnt_hi      <= '0;
         n_words     <= '0;
         acc         <= '0;
         o_ByteReady <= 1'b0;
         o_CpuHold   <= 1'b1;
         o_Done      <= 1'b0;
         o_Error     <= 1'b0;
      end else begin
         o_ByteReady <= 1'b1;
         if (start) begin
            state     <= S_CNT_HI;
            acc       <= '0;
            o_CpuHold <= 1'b1;
            o_Done    <= 1'b0;
            o_Error   <= 1'b0;
         end else if (accept) begin
            unique case (state)
               S_CNT_HI: begin
                  cnt_hi <= i_Byte;
                  acc    <= acc ^ i_Byte;
                  state  <= S_CNT_LO;
               end
               S_CNT_LO: begin
                  n_words <= count;
                  acc     <= acc ^ i_Byte;
                  if (count > DEPTH_N) begin
                     state   <= S_ERROR;
                     o_Error <= 1'b1;
                  end else if (count == '0) begin
                     state <= S_CHECK;
                  end else begin
                     state <= S_DATA;
                  end
               end
               S_DATA: begin
                  acc <= acc ^ i_Byte;
                  if (word_done &&
                      o_WordsLoaded == n_words - CNT_W'(1))
                     state <= S_CHECK;
               end
               S_CHECK: begin
                  if (i_Byte == acc) begin
                     state     <= S_DONE;
                     o_Done    <= 1'b1;
                     o_CpuHold <= 1'b0;
                  end else begin
                     state   <= S_ERROR;
                     o_Error <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
